// File: rtl/param_uart_prog.sv
// UART command receiver: decodes 8N1 frames carrying {2'b10, sel[1:0], value[3:0]} and pulses reprogram on a valid command.
// Optional even-parity bit after bit 7 when PARAM_UART_PARITY_EN is defined.
module param_uart_prog #(
    parameter int CLKS_PER_BIT = 10416
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       rx,
    output logic       reprogram,
    output logic [1:0] time_param_sel,
    output logic [3:0] time_value,
    output logic       busy,
    output logic       err
);

    localparam logic [15:0] FULL_M1 = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] HALF_M1 = 16'((CLKS_PER_BIT / 2) - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef PARAM_UART_PARITY_EN
        PARITY,
`endif
        STOP,
        WAIT_IDLE
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic        r_rx_meta;
    logic        r_rx_sync;
    logic        r_rx_prev;
    logic [15:0] r_cnt;
    logic [15:0] w_cnt_next;
    logic [2:0]  r_bit_idx;
    logic [2:0]  w_bit_idx_next;
    logic [7:0]  r_shift;
    logic [7:0]  w_shift_next;
    logic        r_reprogram;
    logic        w_reprogram_next;
    logic        r_err;
    logic        w_err_next;
    logic        r_busy;
    logic [1:0]  r_sel;
    logic [1:0]  w_sel_next;
    logic [3:0]  r_value;
    logic [3:0]  w_value_next;
    logic        w_cnt_full;
    logic        w_parity_ok;
    logic        w_frame_ok;

`ifdef PARAM_UART_PARITY_EN
    logic        r_parity;
    logic        w_parity_next;
    assign w_parity_ok = ~(^{r_shift, r_parity});
`else
    assign w_parity_ok = 1'b1;
`endif

    assign w_cnt_full = (r_cnt == FULL_M1);
    assign w_frame_ok = r_rx_sync && (r_shift[7:6] == 2'b10) && w_parity_ok;

    always_comb begin
        w_state_next     = r_state;
        w_cnt_next       = r_cnt;
        w_bit_idx_next   = r_bit_idx;
        w_shift_next     = r_shift;
        w_reprogram_next = 1'b0;
        w_err_next       = 1'b0;
        w_sel_next       = r_sel;
        w_value_next     = r_value;
`ifdef PARAM_UART_PARITY_EN
        w_parity_next    = r_parity;
`endif
        case (r_state)
            IDLE: begin
                w_cnt_next     = 16'd0;
                w_bit_idx_next = 3'd0;
                if (r_rx_prev && !r_rx_sync) begin
                    w_state_next = START;
                end
            end
            START: begin
                // Re-check the line at mid start bit to reject glitches.
                if (r_cnt == HALF_M1) begin
                    w_cnt_next   = 16'd0;
                    w_state_next = r_rx_sync ? IDLE : DATA;
                end else begin
                    w_cnt_next = r_cnt + 16'd1;
                end
            end
            DATA: begin
                if (w_cnt_full) begin
                    w_cnt_next     = 16'd0;
                    w_shift_next   = {r_rx_sync, r_shift[7:1]};
                    w_bit_idx_next = r_bit_idx + 3'd1;
                    if (r_bit_idx == 3'd7) begin
`ifdef PARAM_UART_PARITY_EN
                        w_state_next = PARITY;
`else
                        w_state_next = STOP;
`endif
                    end
                end else begin
                    w_cnt_next = r_cnt + 16'd1;
                end
            end
`ifdef PARAM_UART_PARITY_EN
            PARITY: begin
                if (w_cnt_full) begin
                    w_cnt_next    = 16'd0;
                    w_parity_next = r_rx_sync;
                    w_state_next  = STOP;
                end else begin
                    w_cnt_next = r_cnt + 16'd1;
                end
            end
`endif
            STOP: begin
                if (w_cnt_full) begin
                    w_cnt_next = 16'd0;
                    if (w_frame_ok) begin
                        w_reprogram_next = 1'b1;
                        w_sel_next       = r_shift[5:4];
                        w_value_next     = r_shift[3:0];
                        w_state_next     = IDLE;
                    end else begin
                        w_err_next   = 1'b1;
                        w_state_next = r_rx_sync ? IDLE : WAIT_IDLE;
                    end
                end else begin
                    w_cnt_next = r_cnt + 16'd1;
                end
            end
            WAIT_IDLE: begin
                // Line must stay high for a full bit time before re-arming.
                if (!r_rx_sync) begin
                    w_cnt_next = 16'd0;
                end else if (w_cnt_full) begin
                    w_cnt_next   = 16'd0;
                    w_state_next = IDLE;
                end else begin
                    w_cnt_next = r_cnt + 16'd1;
                end
            end
            default: begin
                w_state_next = IDLE;
                w_cnt_next   = 16'd0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= IDLE;
            r_rx_meta   <= 1'b1;
            r_rx_sync   <= 1'b1;
            r_rx_prev   <= 1'b1;
            r_cnt       <= 16'd0;
            r_bit_idx   <= 3'd0;
            r_shift     <= 8'd0;
            r_reprogram <= 1'b0;
            r_err       <= 1'b0;
            r_busy      <= 1'b0;
            r_sel       <= 2'b00;
            r_value     <= 4'h0;
`ifdef PARAM_UART_PARITY_EN
            r_parity    <= 1'b0;
`endif
        end else begin
            r_state     <= w_state_next;
            r_rx_meta   <= rx;
            r_rx_sync   <= r_rx_meta;
            r_rx_prev   <= r_rx_sync;
            r_cnt       <= w_cnt_next;
            r_bit_idx   <= w_bit_idx_next;
            r_shift     <= w_shift_next;
            r_reprogram <= w_reprogram_next;
            r_err       <= w_err_next;
            r_busy      <= (w_state_next != IDLE);
            r_sel       <= w_sel_next;
            r_value     <= w_value_next;
`ifdef PARAM_UART_PARITY_EN
            r_parity    <= w_parity_next;
`endif
        end
    end

    assign reprogram      = r_reprogram;
    assign err            = r_err;
    assign busy           = r_busy;
    assign time_param_sel = r_sel;
    assign time_value     = r_value;

endmodule

// File: tb/tb_param_uart_prog.sv
// Directed bench for param_uart_prog at CLKS_PER_BIT=16; parity cases build only with PARAM_UART_PARITY_EN.
module tb_param_uart_prog;

    localparam int CPB = 16;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       rx    = 1'b1;
    logic       reprogram;
    logic [1:0] time_param_sel;
    logic [3:0] time_value;
    logic       busy;
    logic       err;

    int n_assert = 0;
    int n_fail   = 0;
    int rp_cyc   = 0;
    int err_cyc  = 0;
    int both_cyc = 0;
    int rp_base;
    int err_base;

    param_uart_prog #(.CLKS_PER_BIT(CPB)) dut (
        .clock          (clock),
        .reset          (reset),
        .rx             (rx),
        .reprogram      (reprogram),
        .time_param_sel (time_param_sel),
        .time_value     (time_value),
        .busy           (busy),
        .err            (err)
    );

    always #5 clock = ~clock;

    // Pulse counters sampled mid-cycle; each registered pulse is seen exactly once per high cycle.
    always @(negedge clock) begin
        if (reprogram) rp_cyc <= rp_cyc + 1;
        if (err) err_cyc <= err_cyc + 1;
        if (reprogram && err) both_cyc <= both_cyc + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic drive_bit(input logic v, input int bits);
        rx = v;
        repeat (bits * CPB) @(negedge clock);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic par, input logic stop, input int stop_bits);
        drive_bit(1'b0, 1);
        for (int i = 0; i < 8; i++) drive_bit(b[i], 1);
`ifdef PARAM_UART_PARITY_EN
        drive_bit(par, 1);
`else
        if (par) rx = 1'b1;
`endif
        drive_bit(stop, stop_bits);
        rx = 1'b1;
    endtask

    task automatic mark;
        rp_base  = rp_cyc;
        err_base = err_cyc;
    endtask

    initial begin
        logic [7:0] b3;
        idle_cycles(3);
        check("reset_reprogram", 32'(reprogram), 32'd0);
        check("reset_err", 32'(err), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_sel", 32'(time_param_sel), 32'd0);
        check("reset_value", 32'(time_value), 32'd0);
        reset = 1'b0;
        idle_cycles(5);

        // Valid command 0x9A: sel=1, value=A
        mark();
        send_frame(8'h9A, 1'b0, 1'b1, 1);
        idle_cycles(32);
        check("9A_reprogram_cycles", 32'(rp_cyc - rp_base), 32'd1);
        check("9A_err_cycles", 32'(err_cyc - err_base), 32'd0);
        check("9A_sel", 32'(time_param_sel), 32'd1);
        check("9A_value", 32'(time_value), 32'hA);
        check("9A_busy_after", 32'(busy), 32'd0);

        // Wrong marker 0x5A
        mark();
        send_frame(8'h5A, 1'b0, 1'b1, 1);
        idle_cycles(32);
        check("5A_err_cycles", 32'(err_cyc - err_base), 32'd1);
        check("5A_reprogram_cycles", 32'(rp_cyc - rp_base), 32'd0);
        check("5A_sel_hold", 32'(time_param_sel), 32'd1);
        check("5A_value_hold", 32'(time_value), 32'hA);

        // 0xA7 with stop held low for 20 bit-times
        mark();
        send_frame(8'hA7, 1'b0, 1'b0, 20);
        check("A7_err_cycles", 32'(err_cyc - err_base), 32'd1);
        idle_cycles(10);
        check("A7_busy_wait_idle", 32'(busy), 32'd1);
        idle_cycles(10);
        check("A7_busy_released", 32'(busy), 32'd0);
        check("A7_reprogram_cycles", 32'(rp_cyc - rp_base), 32'd0);
        check("A7_sel_hold", 32'(time_param_sel), 32'd1);
        check("A7_value_hold", 32'(time_value), 32'hA);

        // 5-cycle glitch on idle line
        mark();
        rx = 1'b0;
        idle_cycles(5);
        check("glitch_busy_start", 32'(busy), 32'd1);
        rx = 1'b1;
        idle_cycles(20);
        check("glitch_busy_after", 32'(busy), 32'd0);
        check("glitch_err_cycles", 32'(err_cyc - err_base), 32'd0);
        check("glitch_reprogram_cycles", 32'(rp_cyc - rp_base), 32'd0);

        // Back-to-back 0x83 then 0xBF
        mark();
        send_frame(8'h83, 1'b0, 1'b1, 1);
        check("b2b_first_sel", 32'(time_param_sel), 32'd0);
        check("b2b_first_value", 32'(time_value), 32'h3);
        send_frame(8'hBF, 1'b0, 1'b1, 1);
        idle_cycles(32);
        check("b2b_reprogram_cycles", 32'(rp_cyc - rp_base), 32'd2);
        check("b2b_err_cycles", 32'(err_cyc - err_base), 32'd0);
        check("b2b_sel", 32'(time_param_sel), 32'd3);
        check("b2b_value", 32'(time_value), 32'hF);

        // Reset in the middle of data bit 4 of a third frame
        mark();
        b3 = 8'h9A;
        drive_bit(1'b0, 1);
        for (int i = 0; i < 4; i++) drive_bit(b3[i], 1);
        rx = b3[4];
        idle_cycles(CPB / 2);
        check("midreset_busy_before", 32'(busy), 32'd1);
        reset = 1'b1;
        idle_cycles(3);
        check("midreset_sel", 32'(time_param_sel), 32'd0);
        check("midreset_value", 32'(time_value), 32'd0);
        check("midreset_busy", 32'(busy), 32'd0);
        rx = 1'b1;
        reset = 1'b0;
        idle_cycles(200);
        check("midreset_reprogram_cycles", 32'(rp_cyc - rp_base), 32'd0);
        check("midreset_err_cycles", 32'(err_cyc - err_base), 32'd0);
        check("midreset_busy_after", 32'(busy), 32'd0);

`ifdef PARAM_UART_PARITY_EN
        mark();
        send_frame(8'h9A, 1'b1, 1'b1, 1);
        idle_cycles(32);
        check("par_bad_err_cycles", 32'(err_cyc - err_base), 32'd1);
        check("par_bad_reprogram_cycles", 32'(rp_cyc - rp_base), 32'd0);
        check("par_bad_value_hold", 32'(time_value), 32'd0);
        mark();
        send_frame(8'h9A, 1'b0, 1'b1, 1);
        idle_cycles(32);
        check("par_ok_reprogram_cycles", 32'(rp_cyc - rp_base), 32'd1);
        check("par_ok_err_cycles", 32'(err_cyc - err_base), 32'd0);
        check("par_ok_value", 32'(time_value), 32'hA);
`endif

        check("never_both_pulses", 32'(both_cyc), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
